// File: rtl/reg_dump_unit_if.sv
// ----------------------------------------------------------------------------
// reg_dump_unit_if
//   Bundles the signals between the register dump unit and its environment:
//   the debug-unit request/status pair, the register-file read port and the
//   UART transmitter handshake.
//
//   Parameters
//     width  : register word width in bits (multiple of 8)
//     length : number of registers walked by a dump
//     NB     : register address width
//
//   Signals
//     start            debug unit -> dump unit   one-cycle dump request
//     busy             dump unit  -> debug unit  dump in progress
//     done             dump unit  -> debug unit  one-cycle completion pulse
//     rf_read_register dump unit  -> reg file    read address
//     rf_read_data     reg file   -> dump unit   read data (1-cycle latency)
//     tx_data          dump unit  -> UART        byte to transmit
//     tx_start         dump unit  -> UART        one-cycle latch strobe
//     tx_done          UART       -> dump unit   one-cycle byte-sent pulse
//
//   Modports
//     master : the dump unit side
//     slave  : the environment side (debug unit, register file, UART)
// ----------------------------------------------------------------------------
interface reg_dump_unit_if #(
   parameter int width  = 32,
   parameter int length = 32,
   parameter int NB     = $clog2(length)
) ();
   logic              start;
   logic              busy;
   logic              done;
   logic [NB-1:0]     rf_read_register;
   logic [width-1:0]  rf_read_data;
   logic [7:0]        tx_data;
   logic              tx_start;
   logic              tx_done;

   modport master (
      input  start,
      input  rf_read_data,
      input  tx_done,
      output rf_read_register,
      output tx_data,
      output tx_start,
      output busy,
      output done
   );

   modport slave (
      output start,
      output rf_read_data,
      output tx_done,
      input  rf_read_register,
      input  tx_data,
      input  tx_start,
      input  busy,
      input  done
   );
endinterface

// File: rtl/reg_dump_unit.sv
// ----------------------------------------------------------------------------
// reg_dump_unit
//   Debug-side reader of the register file. A start pulse in IDLE walks
//   register addresses 0..length-1 through one register-file read port,
//   captures each word and sends it to the UART transmitter MSB byte first,
//   one byte per tx_start/tx_done handshake. done pulses once after the last
//   byte has been shifted out.
//
//   Ports
//     clk    : system clock, all state changes on the rising edge
//     rst_n  : asynchronous active-low reset; aborts any dump in progress
//     bus    : reg_dump_unit_if.master (start/busy/done, register-file read
//              port, UART tx handshake)
// ----------------------------------------------------------------------------
module reg_dump_unit #(
   parameter int width  = 32,
   parameter int length = 32,
   parameter int NB     = $clog2(length)
) (
   input  logic             clk,
   input  logic             rst_n,
   reg_dump_unit_if.master  bus
);

   localparam int             BYTES     = width / 8;
   localparam int             BCW       = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
   localparam logic [NB-1:0]  LAST_IDX  = NB'(length - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT,
      S_LATCH,
      S_SEND,
      S_WAIT_TX,
      S_FIN
   } state_t;

   state_t           state_q, state_d;
   logic [NB-1:0]    index_q, index_d;
   logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
   logic [width-1:0] word_buf_q, word_buf_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic [width-1:0] word_shl;

   logic             tx_start_c;
   logic             busy_c;
   logic             done_c;

   // The word buffer is shifted left one byte per sent byte, so the byte to
   // send next is always in its top 8 bits.
   assign word_shl = word_buf_q << 8;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         index_q    <= '0;
         byte_cnt_q <= '0;
         word_buf_q <= '0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         byte_cnt_q <= byte_cnt_d;
         word_buf_q <= word_buf_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      byte_cnt_d = byte_cnt_q;
      word_buf_d = word_buf_q;
      tx_data_d  = tx_data_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               index_d = '0;
               state_d = S_ADDR;
            end
         end

         // index_q drives the read address directly and only changes on the
         // way into ADDR, so the address is stable through WAIT and LATCH.
         S_ADDR:  state_d = S_WAIT;

         // Covers the register file's registered read.
         S_WAIT:  state_d = S_LATCH;

         // tx_data is loaded on entry to SEND so it is already valid in the
         // cycle the UART sees tx_start.
         S_LATCH: begin
            word_buf_d = bus.rf_read_data;
            tx_data_d  = bus.rf_read_data[width-1 -: 8];
            byte_cnt_d = '0;
            state_d    = S_SEND;
         end

         S_SEND:  state_d = S_WAIT_TX;

         // Only this state consumes tx_done; a tx_done coincident with
         // tx_start (SEND) or arriving anywhere else is ignored.
         S_WAIT_TX: begin
            if (bus.tx_done) begin
               if (byte_cnt_q != LAST_BYTE) begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  word_buf_d = word_shl;
                  tx_data_d  = word_shl[width-1 -: 8];
                  state_d    = S_SEND;
               end else if (index_q != LAST_IDX) begin
                  index_d = index_q + 1'b1;
                  state_d = S_ADDR;
               end else begin
                  state_d = S_FIN;
               end
            end
         end

         S_FIN:   state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      tx_start_c = 1'b0;
      busy_c     = 1'b0;
      done_c     = 1'b0;
      case (state_q)
         S_ADDR, S_WAIT, S_LATCH, S_WAIT_TX: busy_c = 1'b1;
         S_SEND: begin
            busy_c     = 1'b1;
            tx_start_c = 1'b1;
         end
         S_FIN:   done_c = 1'b1;
         default: ;
      endcase
   end

   assign bus.rf_read_register = index_q;
   assign bus.tx_data          = tx_data_q;
   assign bus.tx_start         = tx_start_c;
   assign bus.busy             = busy_c;
   assign bus.done             = done_c;

endmodule

// File: tb/tb_reg_dump_unit.sv
// ----------------------------------------------------------------------------
// tb_reg_dump_unit
//   Directed bench for reg_dump_unit. Two instances: the default 32x32 unit
//   and a 16-bit x 4-register variant. Each has a register-file model
//   (registered read) and a UART model that answers tx_start with tx_done a
//   programmable number of cycles later.
// ----------------------------------------------------------------------------
module tb_reg_dump_unit;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   reg_dump_unit_if #(.width(32), .length(32)) bus ();
   reg_dump_unit_if #(.width(16), .length(4))  bus2 ();

   reg_dump_unit #(.width(32), .length(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   reg_dump_unit #(.width(16), .length(4)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   int errors = 0;
   int n_chk  = 0;

   // ---------------------------------------------------- environment models
   int   tx_delay = 10;
   int   cnt      = 0;
   logic inj      = 1'b0;
   int   cyc      = 0;

   always @(posedge clk) bus.rf_read_data <= 32'hA500_0000 | 32'(bus.rf_read_register);

   assign bus.tx_done = (cnt == 1) | inj;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)              cnt <= 0;
      else if (bus.tx_start)   cnt <= tx_delay;
      else if (cnt != 0)       cnt <= cnt - 1;
   end

   logic [7:0] bytes_q[$];
   int         st_cyc[$];
   int         done_cnt     = 0;
   int         done_cyc     = 0;
   int         last_txd_cyc = 0;

   always @(posedge clk) begin
      if (bus.tx_start) begin
         bytes_q.push_back(bus.tx_data);
         st_cyc.push_back(cyc);
      end
      if (bus.tx_done) last_txd_cyc <= cyc;
      if (bus.done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      cyc <= cyc + 1;
   end

   int         cnt2 = 0;
   logic [7:0] bytes2_q[$];
   int         done2_cnt = 0;

   always @(posedge clk) bus2.rf_read_data <= 16'h1230 + 16'(bus2.rf_read_register);

   assign bus2.tx_done = (cnt2 == 1);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)             cnt2 <= 0;
      else if (bus2.tx_start) cnt2 <= 3;
      else if (cnt2 != 0)     cnt2 <= cnt2 - 1;
   end

   always @(posedge clk) begin
      if (bus2.tx_start) bytes2_q.push_back(bus2.tx_data);
      if (bus2.done)     done2_cnt <= done2_cnt + 1;
   end

   // --------------------------------------------------------------- helpers
   typedef struct {
      int         idx;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[10];
   vec_t tbl2[8];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int k);
      logic [31:0] w;
      w = 32'hA500_0000 | 32'(k / 4);
      return w[31 - 8 * (k % 4) -: 8];
   endfunction

   // Whole 128-byte stream starting at queue position base.
   task automatic chk_stream(input string name, input int base);
      int bad = -1;
      n_chk++;
      if (bytes_q.size() < base + 128) begin
         errors++;
         $display("FAIL %s: got %0d bytes expected %0d", name, bytes_q.size() - base, 128);
      end else begin
         for (int k = 0; k < 128; k++) begin
            if (bad < 0 && bytes_q[base + k] !== exp_byte(k)) bad = k;
         end
         if (bad >= 0) begin
            errors++;
            $display("FAIL %s: byte %0d got %02h expected %02h",
                     name, bad, bytes_q[base + bad], exp_byte(bad));
         end
      end
   endtask

   task automatic pulse_start(output int t);
      @(negedge clk);
      bus.start = 1'b1;
      t = cyc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string name);
      int i = 0;
      while (done_cnt == d0 && i < 5000) begin
         @(negedge clk);
         i++;
      end
      chk(name, int'(done_cnt > d0), 1);
   endtask

   task automatic wait_bytes(input int target, input string name);
      int i = 0;
      while (bytes_q.size() < target && i < 5000) begin
         @(negedge clk);
         i++;
      end
      chk(name, int'(bytes_q.size() >= target), 1);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------ test
   initial begin
      int t, b0, d0, i;

      tbl[0] = '{0,   8'hA5};
      tbl[1] = '{1,   8'h00};
      tbl[2] = '{2,   8'h00};
      tbl[3] = '{3,   8'h00};
      tbl[4] = '{4,   8'hA5};
      tbl[5] = '{7,   8'h01};
      tbl[6] = '{40,  8'hA5};
      tbl[7] = '{43,  8'h0A};
      tbl[8] = '{124, 8'hA5};
      tbl[9] = '{127, 8'h1F};

      tbl2[0] = '{0, 8'h12};
      tbl2[1] = '{1, 8'h30};
      tbl2[2] = '{2, 8'h12};
      tbl2[3] = '{3, 8'h31};
      tbl2[4] = '{4, 8'h12};
      tbl2[5] = '{5, 8'h32};
      tbl2[6] = '{6, 8'h12};
      tbl2[7] = '{7, 8'h33};

      // Reset and idle; start held during reset must be ignored.
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus2.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst rf_read_register", int'(bus.rf_read_register), 0);
      chk("rst tx_data",          int'(bus.tx_data),          0);
      chk("rst tx_start",         int'(bus.tx_start),         0);
      chk("rst busy",             int'(bus.busy),             0);
      chk("rst done",             int'(bus.done),             0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      rst_n     = 1'b1;
      repeat (50) @(negedge clk);
      chk("idle no tx_start",  bytes_q.size(), 0);
      chk("idle busy",         int'(bus.busy), 0);

      // Full dump, 10-cycle UART.
      tx_delay = 10;
      b0 = bytes_q.size();
      d0 = done_cnt;
      pulse_start(t);
      chk("full busy after start", int'(bus.busy), 1);
      chk("full first addr",       int'(bus.rf_read_register), 0);
      wait_done(d0, "full done seen");
      repeat (20) @(negedge clk);
      chk("full byte count",   bytes_q.size() - b0, 128);
      chk("full done count",   done_cnt - d0, 1);
      chk("full done timing",  done_cyc, last_txd_cyc + 1);
      chk("full busy after",   int'(bus.busy), 0);
      chk("full addr holds",   int'(bus.rf_read_register), 31);
      for (int k = 0; k < 10; k++) begin
         if (b0 + tbl[k].idx < bytes_q.size())
            chk($sformatf("full byte[%0d]", tbl[k].idx),
                int'(bytes_q[b0 + tbl[k].idx]), int'(tbl[k].exp));
         else
            chk($sformatf("full byte[%0d] present", tbl[k].idx), 0, 1);
      end
      chk_stream("full stream", b0);

      // Latency with a 1-cycle UART.
      tx_delay = 1;
      b0 = bytes_q.size();
      d0 = done_cnt;
      pulse_start(t);
      wait_done(d0, "lat done seen");
      repeat (5) @(negedge clk);
      chk("lat byte count", bytes_q.size() - b0, 128);
      if (st_cyc.size() >= b0 + 5) begin
         chk("lat first tx_start", st_cyc[b0] - t, 4);
         chk("lat intra-word gap", st_cyc[b0 + 1] - st_cyc[b0], 2);
         chk("lat inter-word gap", st_cyc[b0 + 4] - st_cyc[b0 + 3], 5);
      end
      chk_stream("lat stream", b0);

      // Spurious tx_done in ADDR/WAIT/LATCH/SEND and start at byte 40.
      tx_delay = 10;
      b0 = bytes_q.size();
      d0 = done_cnt;
      pulse_start(t);
      inj = 1'b1;
      repeat (4) @(negedge clk);
      inj = 1'b0;
      wait_bytes(b0 + 40, "spur reach byte 40");
      pulse_start(t);
      wait_done(d0, "spur done seen");
      repeat (20) @(negedge clk);
      chk("spur byte count", bytes_q.size() - b0, 128);
      chk("spur done count", done_cnt - d0, 1);
      chk_stream("spur stream", b0);

      // tx_done never arrives: stays busy in WAIT_TX.
      tx_delay = 0;
      b0 = bytes_q.size();
      pulse_start(t);
      repeat (100) @(negedge clk);
      chk("stall byte count", bytes_q.size() - b0, 1);
      chk("stall busy",       int'(bus.busy), 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset while waiting on register 7 byte 2.
      tx_delay = 10;
      b0 = bytes_q.size();
      pulse_start(t);
      wait_bytes(b0 + 31, "mid reach r7b2");
      repeat (3) @(negedge clk);
      chk("mid busy before rst", int'(bus.busy), 1);
      rst_n = 1'b0;
      #1;
      chk("mid rst rf_read_register", int'(bus.rf_read_register), 0);
      chk("mid rst tx_data",          int'(bus.tx_data),          0);
      chk("mid rst busy",             int'(bus.busy),             0);
      chk("mid rst tx_start",         int'(bus.tx_start),         0);
      @(negedge clk);
      rst_n = 1'b1;
      b0 = bytes_q.size();
      repeat (20) @(negedge clk);
      chk("mid no resume", bytes_q.size() - b0, 0);
      d0 = done_cnt;
      pulse_start(t);
      wait_done(d0, "mid done seen");
      repeat (5) @(negedge clk);
      if (bytes_q.size() > b0) chk("mid restart first byte", int'(bytes_q[b0]), 8'hA5);
      chk_stream("mid stream", b0);

      // 16-bit x 4 variant.
      b0 = bytes2_q.size();
      d0 = done2_cnt;
      @(negedge clk);
      bus2.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      i = 0;
      while (done2_cnt == d0 && i < 2000) begin
         @(negedge clk);
         i++;
      end
      repeat (5) @(negedge clk);
      chk("var done count", done2_cnt - d0, 1);
      chk("var byte count", bytes2_q.size() - b0, 8);
      for (int k = 0; k < 8; k++) begin
         if (b0 + tbl2[k].idx < bytes2_q.size())
            chk($sformatf("var byte[%0d]", tbl2[k].idx),
                int'(bytes2_q[b0 + tbl2[k].idx]), int'(tbl2[k].exp));
         else
            chk($sformatf("var byte[%0d] present", tbl2[k].idx), 0, 1);
      end
      chk("var busy after", int'(bus2.busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, n_chk);
      $finish;
   end

endmodule

// File: doc/reg_dump_unit.md
Name: reg_dump_unit

Overview:
- Debug-side reader of the MIPS register file. On a start pulse it walks register addresses 0..length-1 through one register-file read port.
- It captures each word and serializes it MSB-byte-first to the UART transmitter using a start/done handshake.
- It sits between the debug unit, the register file's read port and the UART tx block.
- The CPU is halted while a dump runs; write/read coherency with the pipeline is outside this block.

Parameters:
- width, 32, register word width in bits; must be a multiple of 8.
- length, 32, number of registers to dump.
- NB, $clog2(length), register address width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- rf_read_register  output  NB  address driven to the register-file read port.
- rf_read_data  input  width  register-file read data; registered by the file on posedge, so 1-cycle latency.
- tx_data  output  8  byte presented to the UART transmitter.
- tx_start  output  1  one-cycle pulse: UART latches tx_data.
- tx_done  input  1  one-cycle pulse from UART: byte fully shifted out.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last byte's tx_done.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rf_read_register=0, tx_data=0, tx_start=0, busy=0, done=0; word buffer, byte counter and register index cleared. Reset mid-dump aborts immediately and nothing resumes; after release the unit waits for a new start.
- BYTES = width/8; byte counter width is $clog2(BYTES) with a minimum of 1.
- States:
  - IDLE: start=1 -> ADDR, index=0, busy=1. Otherwise stay.
  - ADDR: drive rf_read_register=index -> WAIT.
  - WAIT: one cycle covering the file's registered read -> LATCH.
  - LATCH: word_buf<=rf_read_data, byte_cnt=0 -> SEND.
  - SEND: tx_data<=word_buf[width-1-8*byte_cnt -: 8]; tx_start=1 for exactly this cycle -> WAIT_TX.
  - WAIT_TX: hold tx_data; on tx_done:
    - if byte_cnt<BYTES-1: byte_cnt++ -> SEND.
    - else if index<length-1: index++ -> ADDR.
    - else -> FIN.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- rf_read_register holds its value from ADDR until the next ADDR, so the address is stable across WAIT and LATCH.
- Timing:
  - Start accepted at cycle T. The first tx_start is at T+4 (ADDR T+1, WAIT T+2, LATCH T+3, SEND T+4).
  - Each byte after the first: tx_start is asserted 1 cycle after the previous tx_done.
  - Each new register: tx_start is asserted 4 cycles after the last byte's tx_done.
- Total bytes per dump = length*BYTES (128 at defaults). Byte order: r0 MSB, r0 ..., r0 LSB, r1 MSB, ..., r31 LSB.
- Boundary conditions:
  - start while busy: ignored; no restart, no counter disturbance.
  - tx_done outside WAIT_TX: ignored.
  - tx_done in the same cycle as tx_start: ignored, since the UART cannot finish in 0 cycles. Only WAIT_TX consumes tx_done.
  - Index wrap: after index length-1 the unit never reissues address 0 in the same dump. rf_read_register keeps length-1 until the next dump's ADDR.
  - tx_done never arrives: the unit stays in WAIT_TX indefinitely with busy=1. No timeout.
  - start and reset asserted together: reset wins.
  - start on the FIN cycle: ignored. A new dump requires start while in IDLE.

Test Plan:
- Reset and idle. Register-file model with reg[i]=32'hA5000000|i; UART model returns tx_done 10 cycles after each tx_start. Assert rst_n=0 then 1 with start=0 -> all outputs 0, no tx_start for 50 cycles.
- Full dump. Pulse start -> exactly 128 tx_start pulses. Byte stream begins A5 00 00 00, A5 00 00 01 and ends A5 00 00 1F. done pulses once, 1 cycle after the 128th tx_done; busy=0 afterwards.
- Latency check. tx_done delay set to 1 cycle -> first tx_start at start+4. Intra-word tx_start spacing is 2 cycles; inter-word spacing is 5 cycles.
- Spurious handshakes:
  - Inject tx_done during ADDR/WAIT/LATCH -> byte order unchanged and still 128 bytes.
  - Pulse start at byte 40 -> no restart; stream identical to the full-dump case.
- Reset mid-operation. Assert rst_n=0 while in WAIT_TX on register 7 byte 2 -> outputs 0 immediately. Release and pulse start -> dump restarts from r0 MSB (A5).
- Parameter variant. width=16, length=4, reg[i]=16'h1230+i -> stream 12 30 12 31 12 32 12 33, then done.
